// File: rtl/resp_compactor.sv
// Response compactor: folds a counted run of DUT response words into a
// MISR signature and compares it against a golden value.
module resp_compactor #(
  parameter int              WIDTH   = 8,
  parameter int              SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h8005,
  parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
  parameter int              COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0]   golden,
  input  logic               resp_valid,
  input  logic [WIDTH-1:0]   resp_data,
  output logic               resp_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [SIG_W-1:0]   signature,
  output logic [COUNT_W-1:0] pat_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [SIG_W-1:0]   sig_q, sig_n;
  logic [COUNT_W-1:0] cnt_q, cnt_n;
  logic [COUNT_W-1:0] num_q, num_n;
  logic               pass_q, pass_n;
  logic [SIG_W-1:0]   fb;
  logic [SIG_W-1:0]   misr;

  assign fb   = sig_q[SIG_W-1] ? POLY : '0;
  assign misr = {sig_q[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sig_q  <= SEED;
      cnt_q  <= '0;
      num_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      sig_q  <= sig_n;
      cnt_q  <= cnt_n;
      num_q  <= num_n;
      pass_q <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    sig_n   = sig_q;
    cnt_n   = cnt_q;
    num_n   = num_q;
    pass_n  = pass_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          num_n   = num_patterns;
          sig_n   = SEED;
          cnt_n   = '0;
          pass_n  = 1'b0;
          state_n = (num_patterns != '0) ? RUN : CHECK;
        end
      end
      RUN: begin
        if (resp_valid) begin
          sig_n = misr;
          cnt_n = cnt_q + COUNT_W'(1);
          if (cnt_n == num_q) state_n = CHECK;
        end
      end
      CHECK: begin
        pass_n  = (sig_q == golden);
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign resp_ready = (state == RUN);
  assign busy       = (state == RUN) || (state == CHECK);
  assign done       = (state == DONE);
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign pat_count  = cnt_q;

endmodule

// File: tb/tb_resp_compactor.sv
// Directed bench for resp_compactor: vector table of full runs plus
// hand sequences for bubbles, empty runs, ignored inputs and async reset.
module tb_resp_compactor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_patterns;
  logic [15:0] golden;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pat_count;

  int total;
  int bad;

  resp_compactor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_patterns (num_patterns),
    .golden       (golden),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .pat_count    (pat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     num;
    logic [15:0]     gold;
    logic [3:0][7:0] d;
    logic [15:0]     sig;
    logic            ok;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] n, input logic [15:0] g);
    @(negedge clk);
    start        = 1'b1;
    num_patterns = n;
    golden       = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    chk("ready_run", {31'b0, resp_ready}, 32'd1);
    resp_valid = 1'b1;
    resp_data  = d;
    @(negedge clk);
    resp_valid = 1'b0;
    resp_data  = 8'h00;
  endtask

  task automatic finish_run(input string nm, input logic [15:0] sig,
                            input logic ok, input logic [15:0] cnt);
    chk({nm, "_check_busy"}, {30'b0, busy, done}, 32'b10);
    @(negedge clk);
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_pass"}, {31'b0, pass}, {31'b0, ok});
    chk({nm, "_sig"}, {16'b0, signature}, {16'b0, sig});
    chk({nm, "_cnt"}, {16'b0, pat_count}, {16'b0, cnt});
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    num_patterns = '0;
    golden       = '0;
    resp_valid   = 1'b0;
    resp_data    = '0;

    vt[0] = '{16'd1, 16'h7FFA, {8'h0, 8'h0, 8'h0, 8'h01}, 16'h7FFA, 1'b1};
    vt[1] = '{16'd1, 16'h0000, {8'h0, 8'h0, 8'h0, 8'h01}, 16'h7FFA, 1'b0};
    vt[2] = '{16'd2, 16'hFFF4, {8'h0, 8'h0, 8'h00, 8'h01}, 16'hFFF4, 1'b1};
    vt[3] = '{16'd3, 16'h7F6D, {8'h0, 8'h80, 8'h00, 8'h01}, 16'h7F6D, 1'b1};
    vt[4] = '{16'd1, 16'h0000, {8'h0, 8'h0, 8'h0, 8'hFF}, 16'h7F04, 1'b0};

    #12;
    chk("rst_sig", {16'b0, signature}, 32'h0000FFFF);
    chk("rst_flags", {28'b0, resp_ready, busy, done, pass}, 32'd0);
    chk("rst_cnt", {16'b0, pat_count}, 32'd0);
    rst_n = 1'b1;

    // responses offered in IDLE are ignored
    @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = 8'hAA;
    @(negedge clk);
    chk("idle_ready", {31'b0, resp_ready}, 32'd0);
    @(negedge clk);
    chk("idle_sig", {16'b0, signature}, 32'h0000FFFF);
    resp_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_start(vt[i].num, vt[i].gold);
      chk($sformatf("v%0d_cleared", i), {30'b0, done, pass}, 32'd0);
      for (int j = 0; j < int'(vt[i].num); j++) send(vt[i].d[j]);
      finish_run($sformatf("v%0d", i), vt[i].sig, vt[i].ok, vt[i].num);
    end

    // bubbles between transfers do not disturb the signature
    do_start(16'd2, 16'hFFF4);
    send(8'h01);
    for (int k = 0; k < 3; k++) begin
      chk("bub_ready", {31'b0, resp_ready}, 32'd1);
      chk("bub_sig", {16'b0, signature}, 32'h00007FFA);
      @(negedge clk);
    end
    send(8'h00);
    finish_run("bub", 16'hFFF4, 1'b1, 16'd2);

    // empty run skips RUN, done two cycles after start
    do_start(16'd0, 16'hFFFF);
    chk("zero_check", {29'b0, resp_ready, busy, done}, 32'b010);
    @(negedge clk);
    chk("zero_done", {29'b0, resp_ready, done, pass}, 32'b011);
    chk("zero_sig", {16'b0, signature}, 32'h0000FFFF);

    // responses offered in DONE are ignored
    resp_valid = 1'b1;
    resp_data  = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    chk("done_ready", {31'b0, resp_ready}, 32'd0);
    chk("done_sig", {16'b0, signature}, 32'h0000FFFF);
    resp_valid = 1'b0;

    // start pulsed mid-run must not restart or reload the count
    do_start(16'd2, 16'hFFF4);
    send(8'h01);
    start        = 1'b1;
    num_patterns = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_ready", {31'b0, resp_ready}, 32'd1);
    chk("midstart_cnt", {16'b0, pat_count}, 32'd1);
    chk("midstart_sig", {16'b0, signature}, 32'h00007FFA);
    send(8'h00);
    finish_run("midstart", 16'hFFF4, 1'b1, 16'd2);

    // asynchronous reset in the middle of a run
    do_start(16'd4, 16'h0000);
    send(8'h01);
    send(8'h00);
    chk("pre_rst_cnt", {16'b0, pat_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sig", {16'b0, signature}, 32'h0000FFFF);
    chk("arst_cnt", {16'b0, pat_count}, 32'd0);
    chk("arst_flags", {28'b0, resp_ready, busy, done, pass}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(16'd1, 16'h7FFA);
    send(8'h01);
    finish_run("post_rst", 16'h7FFA, 1'b1, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resp_compactor.md
Name: resp_compactor

Overview:
- Response-side companion to the pattern-application flow: the fault simulator drives patterns into the DUT, and this block captures the DUT output responses.
- Compacts a programmed number of responses into a multiple-input signature register (MISR).
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the DUT outputs and the test controller in BIST-style fault-coverage benches.

Parameters:
- WIDTH, 8, response word width; must be <= SIG_W.
- SIG_W, 16, signature register width.
- POLY, 16'h8005, MISR feedback polynomial (taps XORed in when MSB is 1).
- SEED, 16'hFFFF, signature value loaded at start.
- COUNT_W, 16, width of the pattern counter and num_patterns.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a compaction run; sampled in IDLE or DONE only.
- num_patterns  input  COUNT_W  number of responses to compact; sampled on start.
- golden  input  SIG_W  expected signature; sampled in CHECK.
- resp_valid  input  1  response word present.
- resp_data  input  WIDTH  DUT response word.
- resp_ready  output  1  block accepts a response this cycle.
- busy  output  1  high in RUN and CHECK.
- done  output  1  high in DONE.
- pass  output  1  signature == golden; valid while done=1.
- signature  output  SIG_W  current MISR contents.
- pat_count  output  COUNT_W  responses accepted in the current run.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asynchronous, any state including mid-run):
  - state=IDLE, signature=SEED, pat_count=0.
  - resp_ready=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE, on start=1:
  - Latch num_patterns; signature<=SEED; pat_count<=0.
  - Next state RUN if num_patterns!=0, else CHECK.
- RUN:
  - resp_ready=1 combinationally from state.
  - A transfer occurs when resp_valid && resp_ready.
  - On transfer: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended resp_data.
  - On transfer: pat_count <= pat_count+1.
  - A transfer that makes pat_count equal the latched num_patterns moves to CHECK next cycle.
  - No transfer: all state holds. Idle cycles and bubbles do not affect the signature.
- CHECK (exactly 1 cycle):
  - resp_ready=0.
  - pass <= (signature == golden), using golden sampled this cycle.
  - Next state DONE.
- DONE:
  - done=1; pass, signature and pat_count held.
  - start=1 restarts exactly as from IDLE: clears done and pass, loads SEED.
- Handshake rules:
  - resp_valid outside RUN is ignored; resp_ready=0 there.
  - start in RUN or CHECK is ignored.
- Latency: first transfer possible the cycle after start. done rises 2 cycles after the final transfer (CHECK, then DONE).
- Counter: pat_count never wraps within a run; a maximum num_patterns of 2^COUNT_W-1 is supported.
- Width rule: resp_data occupies signature LSBs [WIDTH-1:0]; upper bits receive 0.

Test Plan:
1. Reset then start with num_patterns=1, golden=16'h7FFA; send resp_data=8'h01 -> signature=16'h7FFA, done=1, pass=1, pat_count=1.
2. As scenario 1 but golden=16'h0000 -> done=1, pass=0, signature=16'h7FFA.
3. num_patterns=2, golden=16'hFFF4; send 8'h01, then 3 idle cycles, then 8'h00 -> signature 7FFA after first transfer, FFF4 after second; pass=1; resp_ready held 1 during idle cycles.
4. num_patterns=0, golden=16'hFFFF, start -> RUN skipped, resp_ready never asserts, done=1 two cycles after start, pass=1.
5. resp_valid=1 with data 8'hAA in IDLE and DONE; start pulses during RUN -> resp_ready=0 outside RUN, signature unchanged, start in RUN has no effect.
6. num_patterns=4; after 2 transfers assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately to reset values; a fresh run after release behaves as scenario 1.
